minmax_tracker: RTL and testbench
=================================

# minmax_tracker

Streaming 4-bit signed statistics stage placed directly downstream of the signed comparator. Samples arrive one per cycle on a valid/ready interface. Each sample is compared, two's-complement signed, against the running minimum and maximum of the current frame. At the end of each WINDOW-sample frame, or on an early flush, the block presents min, max, their first-occurrence indices, the sample count and the range on a held output handshake.

## Interface
- WIDTH, 4: sample width, two's-complement signed.
- WINDOW, 8: samples per frame; legal range 1..2**CNT_W-1.
- CNT_W, 4: width of the count and index fields.
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  signed sample.
- flush  in  1  close the current frame early.
- out_valid  out  1  frame result available.
- out_ready  in  1  consumer accepts the result.
- min_val, max_val  out  WIDTH  signed frame minimum / maximum.
- min_idx, max_idx  out  CNT_W  0-based position of the first occurrence of the min / max within the frame.
- count  out  CNT_W  number of samples in the frame.
- range_val  out  WIDTH+1  unsigned max_val − min_val.

## Operation
- A sample is accepted on a cycle with in_valid && in_ready.
- States:
  - IDLE: no samples in the frame yet.
  - ACCUM: 1..WINDOW−1 samples held.
  - DONE: result held.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE, and 0 while reset is high.
- First accept in IDLE:
  - min = max = sample; min_idx = max_idx = 0; count = 1.
  - Go to ACCUM, or straight to DONE if WINDOW == 1.
- Accept in ACCUM:
  - If sample < min (signed), update min and min_idx = count.
  - If sample > max (signed), update max and max_idx = count.
  - Equal values never update either extremum, so the earliest index is kept.
  - count increments; when the new count == WINDOW, go to DONE.
- flush in ACCUM:
  - Go to DONE with the partial frame.
  - If a sample is accepted in the same cycle, it is included first, then DONE.
- flush in IDLE with no accepted sample is ignored, so an empty frame is never emitted.
- flush in IDLE with a simultaneous accept closes a one-sample frame.
- flush in DONE is ignored.
- DONE behaviour:
  - out_valid = 1; all result outputs held stable.
  - On out_valid && out_ready, go to IDLE.
  - Because in_ready = 0 in DONE, no sample is accepted on the handshake cycle.
- range_val = sign-extended max − sign-extended min, computed at WIDTH+1 bits. It is always non-negative, 0..2**WIDTH−1.
- Result outputs are registered and change only when entering DONE or on reset.

## Timing
- Reset values: out_valid = 0, min_val = max_val = 0, min_idx = max_idx = 0, count = 0, range_val = 0, state = IDLE. in_ready goes to 1 on the first clock edge after reset deasserts.
- Reset asserted mid-frame or in DONE discards all partial state; the next accepted sample is index 0.
- Latency: out_valid rises on the cycle after the edge that accepts the WINDOW-th sample (or the flush edge).
- Full throughput: WINDOW accept cycles plus at least 1 DONE cycle per frame.
- Minimum frame period: WINDOW+1 cycles with out_ready tied high.
- Backpressure: while out_ready = 0, DONE and all outputs are held indefinitely, and in_ready stays 0 so no sample is lost.
- in_data is sampled only on accept cycles; its value at any other time is don't-care.

## Test plan
- Full frame: accept 0, −7, 1, −6, 2, −2, 3, 3 (4'sb0000, 1001, 0001, 1010, 0010, 1110, 0011, 0011) → min_val = −7, min_idx = 1, max_val = 3, max_idx = 6, count = 8, range_val = 10. out_valid rises the cycle after the 8th accept.
- Ties: eight samples of 4'sb0100 → min_val = max_val = 4, both indices 0, range_val = 0.
- Extremes: 7, −8, then six 0s → max_val = 7, max_idx = 0, min_val = −8, min_idx = 1, range_val = 5'b01111.
- Backpressure: complete a frame, hold out_ready = 0 for 5 cycles with in_valid = 1 → in_ready = 0 and outputs constant throughout. After the out_ready pulse, the next frame's first accept is on the following cycle with index 0.
- Flush: accept 5, −1, 2, then pulse flush with in_valid = 0 → count = 3, max_val = 5, max_idx = 0, min_val = −1, min_idx = 1, range_val = 6.
- Flush edge cases:
  - flush in IDLE with in_valid = 0 → no out_valid.
  - flush together with the 2nd sample → count = 2, and that sample is included.
- Reset mid-frame: after 4 accepts, assert reset asynchronously between edges → all outputs 0 at once. The next full frame reports count = 8 with indices relative to the new frame.

Source files
------------

// File: rtl/minmax_tracker.sv
// minmax_tracker: streaming signed min/max statistics over WINDOW-sample frames.
// Samples are accepted on a valid/ready input. When a frame closes (full window
// or early flush), its result is held on a valid/ready output until taken.
module minmax_tracker #(
  parameter int WIDTH  = 4,
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] min_val,
  output logic [WIDTH-1:0] max_val,
  output logic [CNT_W-1:0] min_idx,
  output logic [CNT_W-1:0] max_idx,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH:0]   range_val
);

  localparam logic [CNT_W-1:0] WIN = CNT_W'(WINDOW);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  // running frame statistics, kept apart from the registered result
  typedef struct packed {
    logic signed [WIDTH-1:0] mn;
    logic signed [WIDTH-1:0] mx;
    logic [CNT_W-1:0]        mn_idx;
    logic [CNT_W-1:0]        mx_idx;
    logic [CNT_W-1:0]        cnt;
  } acc_t;

  state_t state, state_nxt;
  acc_t   acc, acc_nxt;

  logic                    rdy_en;
  logic                    accept;
  logic                    win_hit;
  logic                    enter_done;
  logic signed [WIDTH-1:0] samp;
  logic [WIDTH:0]          rng_nxt;

  // rdy_en is cleared asynchronously by reset and comes back on the first
  // edge after release, so in_ready is low throughout reset
  assign in_ready   = rdy_en && (state != DONE);
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state == DONE);
  assign samp       = in_data;
  assign win_hit    = accept && (acc_nxt.cnt == WIN);
  assign enter_done = (state != DONE) && (state_nxt == DONE);

  // range at WIDTH+1 bits so max-min never overflows
  assign rng_nxt = {acc_nxt.mx[WIDTH-1], acc_nxt.mx} - {acc_nxt.mn[WIDTH-1], acc_nxt.mn};

  // fold the accepted sample into the running statistics
  always_comb begin
    acc_nxt = acc;
    if (accept) begin
      if (state == IDLE) begin
        acc_nxt.mn     = samp;
        acc_nxt.mx     = samp;
        acc_nxt.mn_idx = '0;
        acc_nxt.mx_idx = '0;
        acc_nxt.cnt    = CNT_W'(1);
      end else begin
        // strict compares: ties keep the earliest index
        if (samp < acc.mn) begin
          acc_nxt.mn     = samp;
          acc_nxt.mn_idx = acc.cnt;
        end
        if (samp > acc.mx) begin
          acc_nxt.mx     = samp;
          acc_nxt.mx_idx = acc.cnt;
        end
        acc_nxt.cnt = acc.cnt + CNT_W'(1);
      end
    end
  end

  // frame sequencing: fill, close on full window or flush, hold until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // flush with nothing accepted would be an empty frame; ignore it
        if (accept) state_nxt = (win_hit || flush) ? DONE : ACCUM;
      end
      ACCUM: begin
        if (win_hit || flush) state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register and input-ready enable
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
    end
  end

  // running statistics update only on accepted samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else if (accept) acc <= acc_nxt;
  end

  // result registers load once, on the edge that closes the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_val   <= '0;
      max_val   <= '0;
      min_idx   <= '0;
      max_idx   <= '0;
      count     <= '0;
      range_val <= '0;
    end else if (enter_done) begin
      min_val   <= acc_nxt.mn;
      max_val   <= acc_nxt.mx;
      min_idx   <= acc_nxt.mn_idx;
      max_idx   <= acc_nxt.mx_idx;
      count     <= acc_nxt.cnt;
      range_val <= rng_nxt;
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Testbench for minmax_tracker: directed frames from the test plan plus random
// traffic, checked by a queue-based scoreboard fed from a frame-level model.
module tb_minmax_tracker;
  localparam int W = 4, WIN = 8, CW = 4;

  logic          clk = 1'b0, reset = 1'b1;
  logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid;
  logic [W-1:0]  min_val, max_val;
  logic [CW-1:0] min_idx, max_idx, count;
  logic [W:0]    range_val;

  minmax_tracker #(.WIDTH(W), .WINDOW(WIN), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .min_val(min_val), .max_val(max_val), .min_idx(min_idx), .max_idx(max_idx),
    .count(count), .range_val(range_val)
  );

  always #5 clk = ~clk;

  typedef struct {int mn; int mx; int mni; int mxi; int cnt; int rng;} res_t;

  int   checks = 0, errors = 0;
  res_t expq[$];
  int   frame[$];
  bit   exp_done = 0, exp_rdy = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // reference: scan the frame's sample list for first-occurrence extremes
  task automatic close_frame();
    res_t r;
    r.mn = frame[0]; r.mx = frame[0]; r.mni = 0; r.mxi = 0;
    for (int i = 1; i < frame.size(); i++) begin
      if (frame[i] < r.mn) begin r.mn = frame[i]; r.mni = i; end
      if (frame[i] > r.mx) begin r.mx = frame[i]; r.mxi = i; end
    end
    r.cnt = frame.size();
    r.rng = r.mx - r.mn;
    expq.push_back(r);
    frame.delete();
    exp_done = 1;
  endtask

  // one cycle: drive, check handshake flags at negedge, advance model at posedge
  task automatic step(input bit v, input logic [W-1:0] d, input bit f, input bit r);
    bit acc;
    in_valid = v; in_data = d; flush = f; out_ready = r;
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(exp_rdy && !exp_done));
    chk("out_valid", int'(out_valid), int'(exp_done));
    acc = v && exp_rdy && !exp_done;
    @(posedge clk);
    if (exp_done) begin
      if (r) exp_done = 0;
    end else begin
      if (acc) frame.push_back(int'($signed(d)));
      if (frame.size() == WIN || (f && frame.size() > 0)) close_frame();
    end
    exp_rdy = 1;
    #1;
  endtask

  // reset asserted between edges; outputs must clear immediately
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst min_val", int'(min_val), 0);
    chk("rst max_val", int'(max_val), 0);
    chk("rst min_idx", int'(min_idx), 0);
    chk("rst max_idx", int'(max_idx), 0);
    chk("rst count", int'(count), 0);
    chk("rst range", int'(range_val), 0);
    frame.delete(); expq.delete();
    exp_done = 0; exp_rdy = 0;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // monitor: whenever a result is presented, compare it to the queue head
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (expq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got out_valid=1 expected no result pending");
      end else begin
        chk("min_val", int'($signed(min_val)), expq[0].mn);
        chk("max_val", int'($signed(max_val)), expq[0].mx);
        chk("min_idx", int'(min_idx), expq[0].mni);
        chk("max_idx", int'(max_idx), expq[0].mxi);
        chk("count", int'(count), expq[0].cnt);
        chk("range_val", int'(range_val), expq[0].rng);
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  logic [W-1:0] f1 [8] = '{4'b0000, 4'b1001, 4'b0001, 4'b1010, 4'b0010, 4'b1110, 4'b0011, 4'b0011};
  logic [W-1:0] f3 [8] = '{4'b0111, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

  initial begin
    @(posedge clk);
    do_reset();

    // full frame from the test plan, then hand off
    for (int i = 0; i < 8; i++) step(1, f1[i], 0, 1);
    step(0, 0, 0, 1);
    // ties
    for (int i = 0; i < 8; i++) step(1, 4'b0100, 0, 1);
    step(0, 0, 0, 1);
    // extremes
    for (int i = 0; i < 8; i++) step(1, f3[i], 0, 1);
    step(0, 0, 0, 1);
    // backpressure: full frame, hold 5 cycles with in_valid high, then release
    for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) step(1, W'($urandom), 0, 0);
    step(1, 4'b0110, 0, 1);
    for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 1);
    step(0, 0, 0, 1);
    // flush after three samples
    step(1, 4'b0101, 0, 1); step(1, 4'b1111, 0, 1); step(1, 4'b0010, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    // flush in IDLE with nothing accepted is ignored
    step(0, 0, 1, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    // flush together with the 2nd sample
    step(1, 4'b1100, 0, 1); step(1, 4'b0011, 1, 1);
    step(0, 0, 0, 1);
    // flush together with the first sample: one-sample frame
    step(1, 4'b1010, 1, 1);
    step(0, 0, 0, 1);
    // reset mid-frame, then a fresh full frame
    for (int i = 0; i < 4; i++) step(1, W'($urandom), 0, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, W'($urandom), 0, 1);
    step(0, 0, 0, 1);

    // random traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) < 7);
    end

    // drain any held result
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("scoreboard_empty", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
